// File: rtl/tart_acquire_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tart_acquire_ctrl_pkg
// Purpose  : Shared constants for the TART acquisition/visibility controller:
//            register map, status bit positions, default widths and the
//            visibility-reader state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tart_acquire_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACCUM = 24;
  localparam int DEF_BBITS = 6;

  // Register map (3-bit bus address)
  localparam logic [2:0] REG_DEBUG     = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_SAMPLE    = 3'd2;
  localparam logic [2:0] REG_CHECKSUM  = 3'd3;
  localparam logic [2:0] REG_VX        = 3'd4;
  localparam logic [2:0] REG_BLOCKSIZE = 3'd5;
  localparam logic [2:0] REG_SPARE     = 3'd6;
  localparam logic [2:0] REG_CTRL      = 3'd7;

  // Status register (address 1) bit positions
  localparam int STAT_AVAILABLE = 0;
  localparam int STAT_ACCESSED  = 1;
  localparam int STAT_STREAMED  = 2;
  localparam int STAT_ENABLED   = 3;

  typedef enum logic [1:0] {
    VX_IDLE = 2'd0,
    VX_WAIT = 2'd1,
    VX_DONE = 2'd2
  } vx_state_t;

endpackage
`default_nettype wire

// File: rtl/tart_vx_reader.sv
`default_nettype none
// ============================================================================
// Module   : tart_vx_reader
// Purpose  : Bridges a host read of the visibility register onto the
//            byte-wide master bus of the correlator, and owns the visibility
//            byte pointer plus the block available/accessed flags.
// Ports    : clk, rst            - clock, async active-high reset
//            start               - host read of the visibility register seen
//            bus_cyc             - host cyc_i, used to abort a transfer
//            vx_ack              - correlator acknowledge
//            newblock            - correlator switched banks
//            done                - byte captured this cycle (ack next cycle)
//            vx_cyc_o, vx_stb_o  - master bus cycle/strobe
//            vx_blk_o            - visibility byte pointer
//            accessed, available - block flags
// Revision : 1.0 - initial release
// ============================================================================
module tart_vx_reader
  import tart_acquire_ctrl_pkg::*;
#(
  parameter int BBITS = DEF_BBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bus_cyc,
  input  logic             vx_ack,
  input  logic             newblock,
  output logic             done,
  output logic             vx_cyc_o,
  output logic             vx_stb_o,
  output logic [BBITS-1:0] vx_blk_o,
  output logic             accessed,
  output logic             available
);

  vx_state_t state, state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= VX_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Dropping cyc_i wins over a simultaneous correlator ack: the host has
  // abandoned the cycle, so the byte is discarded and the pointer kept.
  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      VX_IDLE: if (start) state_n = VX_WAIT;
      VX_WAIT: begin
        if (!bus_cyc) begin
          state_n = VX_IDLE;
        end else if (vx_ack) begin
          state_n = VX_DONE;
          done    = 1'b1;
        end
      end
      VX_DONE: state_n = VX_IDLE;
      default: state_n = VX_IDLE;
    endcase
  end

  assign vx_cyc_o = (state == VX_WAIT);
  assign vx_stb_o = (state == VX_WAIT);

  // The pointer advances in the cycle the host ack is visible (VX_DONE),
  // so the byte just returned belongs to the pre-increment address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_blk_o  <= '0;
      accessed  <= 1'b0;
      available <= 1'b0;
    end else if (newblock) begin
      vx_blk_o  <= '0;
      accessed  <= 1'b0;
      available <= 1'b1;
    end else if (state == VX_DONE) begin
      vx_blk_o <= vx_blk_o + BBITS'(1);
      accessed <= 1'b1;
      if (vx_blk_o == {BBITS{1'b1}}) available <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tart_acquire_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tart_acquire_ctrl
// Purpose  : 8-bit bus slave for TART acquisition control: debug/delay,
//            block-size and enable registers, DRAM sample handshake, status
//            read-back and the visibility read bridge to the correlator.
// Ports    : clk_i, rst_i                  - clock, async active-high reset
//            cyc_i/stb_i/we_i/adr_i/dat_i  - host bus inputs
//            ack_o/dat_o                   - host bus outputs
//            data_ready/data_request/data_in - DRAM sample handshake
//            spi_busy                      - mirrors cyc_i
//            vx_*                          - master bus to the correlator
//            newblock/streamed/checksum    - correlator status inputs
//            accessed/available/blocksize  - block status outputs
//            aq_debug_mode/aq_enabled/aq_sample_delay - acquisition controls
// Revision : 1.0 - initial release
// ============================================================================
module tart_acquire_ctrl
  import tart_acquire_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACCUM = DEF_ACCUM,
  parameter int BBITS = DEF_BBITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  output logic             ack_o,
  input  logic [2:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  input  logic             data_ready,
  output logic             data_request,
  input  logic [23:0]      data_in,
  output logic             spi_busy,
  output logic             vx_cyc_o,
  output logic             vx_stb_o,
  output logic             vx_we_o,
  input  logic             vx_ack_i,
  output logic [BBITS-1:0] vx_blk_o,
  input  logic [7:0]       vx_dat_i,
  input  logic             newblock,
  input  logic             streamed,
  input  logic [ACCUM-1:0] checksum,
  output logic             accessed,
  output logic             available,
  output logic [ACCUM-1:0] blocksize,
  output logic             aq_debug_mode,
  output logic             aq_enabled,
  output logic [2:0]       aq_sample_delay
);

  logic             bus_req;
  logic             vx_start;
  logic             vx_done;
  logic [4:0]       log2_n;
  logic [7:0]       sample_byte;
  logic [WIDTH-1:0] rd_data;
  logic             unused_bits;

  // A strobe is only taken while ack_o is low, giving exactly one ack per
  // strobe and a one-cycle turnaround for back-to-back accesses.
  assign bus_req  = cyc_i && stb_i && !ack_o;
  assign vx_start = bus_req && (adr_i == REG_VX);

  assign spi_busy  = cyc_i;
  assign vx_we_o   = 1'b0;
  assign blocksize = (ACCUM'(1) << log2_n) - ACCUM'(1);

  assign unused_bits = ^{data_in[23:8], checksum[ACCUM-1:8], dat_i[6:5]};

  tart_vx_reader #(
    .BBITS (BBITS)
  ) u_vx_reader (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (vx_start),
    .bus_cyc   (cyc_i),
    .vx_ack    (vx_ack_i),
    .newblock  (newblock),
    .done      (vx_done),
    .vx_cyc_o  (vx_cyc_o),
    .vx_stb_o  (vx_stb_o),
    .vx_blk_o  (vx_blk_o),
    .accessed  (accessed),
    .available (available)
  );

  always_comb begin
    rd_data = '0;
    case (adr_i)
      REG_DEBUG:     rd_data = WIDTH'({aq_debug_mode, 4'b0000, aq_sample_delay});
      REG_STATUS:    rd_data = WIDTH'({aq_enabled, streamed, accessed, available});
      REG_SAMPLE:    rd_data = WIDTH'(sample_byte);
      REG_CHECKSUM:  rd_data = WIDTH'(checksum[7:0]);
      REG_BLOCKSIZE: rd_data = WIDTH'(log2_n);
      REG_CTRL:      rd_data = WIDTH'(aq_enabled);
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o           <= 1'b0;
      dat_o           <= '0;
      aq_debug_mode   <= 1'b0;
      aq_sample_delay <= 3'd0;
      log2_n          <= 5'd0;
      aq_enabled      <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      if (vx_done) begin
        ack_o <= 1'b1;
        dat_o <= WIDTH'(vx_dat_i);
      end else if (bus_req && (adr_i != REG_VX)) begin
        ack_o <= 1'b1;
        dat_o <= rd_data;
        if (we_i) begin
          case (adr_i)
            REG_DEBUG: begin
              aq_debug_mode   <= dat_i[7];
              aq_sample_delay <= dat_i[2:0];
            end
            REG_BLOCKSIZE: log2_n     <= dat_i[4:0];
            REG_CTRL:      aq_enabled <= dat_i[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Requests are spaced at least one cycle apart so the DRAM side can drop
  // data_ready before the next sample is consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_request <= 1'b0;
      sample_byte  <= 8'h00;
    end else begin
      data_request <= aq_enabled && data_ready && !data_request;
      if (aq_enabled && data_ready && !data_request) begin
        sample_byte <= data_in[7:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tart_acquire_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tart_acquire_ctrl
// Purpose  : Directed self-checking bench for tart_acquire_ctrl with a small
//            correlator model that acks visibility reads after a set delay.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_tart_acquire_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic        ack_o;
  logic [2:0]  adr_i = 3'd0;
  logic [7:0]  dat_i = 8'h00;
  logic [7:0]  dat_o;
  logic        data_ready = 1'b0;
  logic        data_request;
  logic [23:0] data_in = 24'h0;
  logic        spi_busy;
  logic        vx_cyc_o, vx_stb_o, vx_we_o;
  logic        vx_ack_i = 1'b0;
  logic [5:0]  vx_blk_o;
  logic [7:0]  vx_dat_i = 8'h00;
  logic        newblock = 1'b0;
  logic        streamed = 1'b0;
  logic [23:0] checksum = 24'h00A5C3;
  logic        accessed, available;
  logic [23:0] blocksize;
  logic        aq_debug_mode, aq_enabled;
  logic [2:0]  aq_sample_delay;

  int checks = 0;
  int failures = 0;

  int dsp_delay = 2;
  bit dsp_hold = 1'b0;
  int dsp_cnt = 0;

  always #5 clk = ~clk;

  tart_acquire_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .ack_o(ack_o), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .data_ready(data_ready), .data_request(data_request), .data_in(data_in),
    .spi_busy(spi_busy), .vx_cyc_o(vx_cyc_o), .vx_stb_o(vx_stb_o),
    .vx_we_o(vx_we_o), .vx_ack_i(vx_ack_i), .vx_blk_o(vx_blk_o),
    .vx_dat_i(vx_dat_i), .newblock(newblock), .streamed(streamed),
    .checksum(checksum), .accessed(accessed), .available(available),
    .blocksize(blocksize), .aq_debug_mode(aq_debug_mode),
    .aq_enabled(aq_enabled), .aq_sample_delay(aq_sample_delay)
  );

  // Correlator model: acks a strobe dsp_delay cycles after it appears,
  // returning a byte derived from the requested pointer.
  always @(posedge clk) begin
    if (vx_stb_o && !vx_ack_i && !dsp_hold) begin
      if (dsp_cnt == dsp_delay - 1) begin
        vx_ack_i <= 1'b1;
        vx_dat_i <= {2'b00, vx_blk_o} ^ 8'h5A;
        dsp_cnt  <= 0;
      end else begin
        dsp_cnt <= dsp_cnt + 1;
      end
    end else begin
      vx_ack_i <= 1'b0;
      dsp_cnt  <= 0;
    end
  end

  // One bus transfer; cycles = negedges until ack_o seen (0 on timeout),
  // vxack_at = negedge index where vx_ack_i was last seen high.
  task automatic bus_xfer(input logic [2:0] adr, input logic we, input logic [7:0] wdata,
                          input bit nb_on_ack, output logic [7:0] rdata,
                          output int cycles, output int vxack_at);
    cycles = 0;
    vxack_at = -1;
    rdata = 8'h00;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wdata;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (vx_ack_i) vxack_at = k;
      if (ack_o) begin
        cycles = k;
        rdata = dat_o;
        break;
      end
    end
    if (nb_on_ack && cycles != 0) newblock = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    newblock = 1'b0;
  endtask

  task automatic pulse_newblock();
    @(negedge clk);
    newblock = 1'b1;
    @(negedge clk);
    newblock = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int cyc, vxa;
    logic [7:0] regs [4];
    regs[0] = 8'd0; regs[1] = 8'd1; regs[2] = 8'd5; regs[3] = 8'd7;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack_o, data_request, vx_cyc_o, vx_stb_o, accessed, available, aq_enabled,
         aq_debug_mode, dat_o, blocksize, vx_blk_o, aq_sample_delay} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b req=%b vxcyc=%b acc=%b avail=%b en=%b dbg=%b dat=%h bs=%h blk=%h, required all zero",
               ack_o, data_request, vx_cyc_o, accessed, available, aq_enabled, aq_debug_mode, dat_o, blocksize, vx_blk_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_xfer(regs[i][2:0], 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
      checks++;
      if (rd !== 8'h00 || cyc !== 1) begin
        failures++;
        $display("FAIL reset_read_reg%0d: data=%h cycles=%0d, required data=00 cycles=1", regs[i], rd, cyc);
      end
    end
  endtask

  task automatic test_registers();
    logic [7:0] rd;
    int cyc, vxa;
    bus_xfer(3'd5, 1'b1, 8'h03, 1'b0, rd, cyc, vxa);
    checks++;
    if (cyc !== 1 || blocksize !== 24'h000007) begin
      failures++;
      $display("FAIL blocksize_write: cycles=%0d blocksize=%h, required cycles=1 blocksize=000007", cyc, blocksize);
    end
    bus_xfer(3'd5, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h03) begin
      failures++;
      $display("FAIL blocksize_read: got %h, required 03", rd);
    end
    bus_xfer(3'd0, 1'b1, 8'h85, 1'b0, rd, cyc, vxa);
    bus_xfer(3'd0, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h85 || aq_debug_mode !== 1'b1 || aq_sample_delay !== 3'd5) begin
      failures++;
      $display("FAIL debug_reg: read=%h dbg=%b delay=%0d, required 85 1 5", rd, aq_debug_mode, aq_sample_delay);
    end
    bus_xfer(3'd1, 1'b1, 8'hFF, 1'b0, rd, cyc, vxa);
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("FAIL ro_write_ack: cycles=%0d, required 1", cyc);
    end
    bus_xfer(3'd1, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("FAIL ro_write_ignored: status=%h, required 00", rd);
    end
    bus_xfer(3'd3, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'hC3) begin
      failures++;
      $display("FAIL checksum_read: got %h, required c3", rd);
    end
    bus_xfer(3'd6, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("FAIL spare_read: got %h, required 00", rd);
    end
  endtask

  task automatic test_acquire();
    logic [7:0] rd;
    int cyc, vxa, pulses;
    bus_xfer(3'd7, 1'b1, 8'h01, 1'b0, rd, cyc, vxa);
    checks++;
    if (aq_enabled !== 1'b1) begin
      failures++;
      $display("FAIL enable_write: aq_enabled=%b, required 1", aq_enabled);
    end
    data_ready = 1'b1;
    data_in = 24'hABCD5E;
    @(negedge clk);
    checks++;
    if (data_request !== 1'b1) begin
      failures++;
      $display("FAIL request_pulse: data_request=%b, required 1", data_request);
    end
    data_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (data_request !== 1'b0) begin
      failures++;
      $display("FAIL request_one_cycle: data_request=%b, required 0", data_request);
    end
    pulses = 0;
    data_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      data_in = {16'h1234, 8'(8'h20 + j)};
      @(negedge clk);
      if (data_request) pulses++;
    end
    data_ready = 1'b0;
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL request_spacing: pulses=%0d, required 3", pulses);
    end
    bus_xfer(3'd2, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h24) begin
      failures++;
      $display("FAIL sample_capture: got %h, required 24", rd);
    end
    bus_xfer(3'd1, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h08) begin
      failures++;
      $display("FAIL status_enabled: got %h, required 08", rd);
    end
    bus_xfer(3'd7, 1'b1, 8'h00, 1'b0, rd, cyc, vxa);
    pulses = 0;
    data_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (data_request) pulses++;
    end
    data_ready = 1'b0;
    checks++;
    if (pulses !== 0 || aq_enabled !== 1'b0) begin
      failures++;
      $display("FAIL disable_stops: pulses=%0d aq_enabled=%b, required 0 0", pulses, aq_enabled);
    end
  endtask

  task automatic test_vx_single();
    logic [7:0] rd;
    int cyc, vxa;
    pulse_newblock();
    checks++;
    if (available !== 1'b1 || accessed !== 1'b0 || vx_blk_o !== 6'd0) begin
      failures++;
      $display("FAIL newblock_flags: avail=%b acc=%b blk=%0d, required 1 0 0", available, accessed, vx_blk_o);
    end
    dsp_delay = 2;
    bus_xfer(3'd4, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (cyc !== 4 || vxa !== 3) begin
      failures++;
      $display("FAIL vx_latency: ack at %0d vx_ack at %0d, required 4 and 3", cyc, vxa);
    end
    checks++;
    if (rd !== 8'h5A || vx_blk_o !== 6'd1) begin
      failures++;
      $display("FAIL vx_single_data: data=%h blk=%0d, required 5a 1", rd, vx_blk_o);
    end
    bus_xfer(3'd1, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h03) begin
      failures++;
      $display("FAIL vx_single_status: got %h, required 03", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int cyc, vxa;
    pulse_newblock();
    dsp_delay = 1;
    for (int i = 0; i < 64; i++) begin
      bus_xfer(3'd4, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
      checks++;
      if (rd !== (8'(i) ^ 8'h5A) || cyc !== 3) begin
        failures++;
        $display("FAIL vx_stream_%0d: data=%h cycles=%0d, required %h 3", i, rd, cyc, 8'(i) ^ 8'h5A);
      end
      if (i == 62) begin
        checks++;
        if (available !== 1'b1 || vx_blk_o !== 6'd63) begin
          failures++;
          $display("FAIL vx_before_wrap: avail=%b blk=%0d, required 1 63", available, vx_blk_o);
        end
      end
    end
    checks++;
    if (available !== 1'b0 || vx_blk_o !== 6'd0 || accessed !== 1'b1) begin
      failures++;
      $display("FAIL vx_wrap: avail=%b blk=%0d acc=%b, required 0 0 1", available, vx_blk_o, accessed);
    end
    bus_xfer(3'd1, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h02) begin
      failures++;
      $display("FAIL vx_wrap_status: got %h, required 02", rd);
    end
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    int cyc, vxa;
    streamed = 1'b1;
    pulse_newblock();
    bus_xfer(3'd4, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    bus_xfer(3'd4, 1'b0, 8'h00, 1'b1, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h5B || vx_blk_o !== 6'd0 || available !== 1'b1 || accessed !== 1'b0) begin
      failures++;
      $display("FAIL newblock_priority: data=%h blk=%0d avail=%b acc=%b, required 5b 0 1 0",
               rd, vx_blk_o, available, accessed);
    end
    bus_xfer(3'd1, 1'b0, 8'h00, 1'b0, rd, cyc, vxa);
    checks++;
    if (rd !== 8'h05) begin
      failures++;
      $display("FAIL status_streamed: got %h, required 05", rd);
    end
    streamed = 1'b0;
  endtask

  task automatic test_abort();
    logic [5:0] blk0;
    int acks;
    dsp_hold = 1'b1;
    blk0 = vx_blk_o;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (vx_cyc_o !== 1'b1 || vx_stb_o !== 1'b1 || vx_we_o !== 1'b0 || spi_busy !== 1'b1) begin
      failures++;
      $display("FAIL vx_hold: cyc=%b stb=%b we=%b busy=%b, required 1 1 0 1", vx_cyc_o, vx_stb_o, vx_we_o, spi_busy);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    checks++;
    if (vx_cyc_o !== 1'b0 || vx_stb_o !== 1'b0 || acks !== 0 || vx_blk_o !== blk0) begin
      failures++;
      $display("FAIL vx_abort: cyc=%b stb=%b acks=%0d blk=%0d, required 0 0 0 %0d", vx_cyc_o, vx_stb_o, acks, vx_blk_o, blk0);
    end
    dsp_hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int cyc, vxa;
    bus_xfer(3'd7, 1'b1, 8'h01, 1'b0, rd, cyc, vxa);
    bus_xfer(3'd5, 1'b1, 8'h04, 1'b0, rd, cyc, vxa);
    dsp_hold = 1'b1;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 3'd4;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (vx_cyc_o !== 1'b0 || aq_enabled !== 1'b0 || blocksize !== 24'h0 || available !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: vxcyc=%b en=%b bs=%h avail=%b, required 0 0 000000 0", vx_cyc_o, aq_enabled, blocksize, available);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    dsp_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_registers();
    test_acquire();
    test_vx_single();
    test_back_to_back();
    test_collision();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
